// File: rtl/svd_jacobi_sched.sv
// Jacobi-schedule sequencer for the SVD CORDIC datapath: per column pair a vectoring
// pass, a rotation pass, then a write-back handshake. Optional abort input: JACOBI_ABORT_EN.
module svd_jacobi_sched #(
    parameter int N_COLS  = 4,
    parameter int IDX_W   = 2,
    parameter int ITER    = 16,
    parameter int SHIFT_W = 4,
    parameter int SWEEPS  = 6,
    parameter int SWEEP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               wb_ack,
`ifdef JACOBI_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               iter_valid,
    output logic               phase,
    output logic               sel,
    output logic [SHIFT_W-1:0] shift_bit,
    output logic [IDX_W-1:0]   p_idx,
    output logic [IDX_W-1:0]   q_idx,
    output logic               wb_req,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    localparam logic [SHIFT_W-1:0] ITER_LAST  = SHIFT_W'(ITER - 1);
    localparam logic [IDX_W-1:0]   Q_LAST     = IDX_W'(N_COLS - 1);
    localparam logic [IDX_W-1:0]   P_LAST     = IDX_W'(N_COLS - 2);
    localparam logic [IDX_W-1:0]   Q_FIRST    = IDX_W'(1);
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEPS - 1);

    typedef enum logic [2:0] {IDLE, VEC, ROT, WB, DONE} state_t;

    state_t             state, state_nxt;
    logic [SHIFT_W-1:0] iter, iter_nxt;
    logic [IDX_W-1:0]   p, p_nxt, q, q_nxt;
    logic [SWEEP_W-1:0] sweep, sweep_nxt;
    logic               abort_req;

`ifdef JACOBI_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            iter  <= '0;
            p     <= '0;
            q     <= Q_FIRST;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
            p     <= p_nxt;
            q     <= q_nxt;
            sweep <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        p_nxt     = p;
        q_nxt     = q;
        sweep_nxt = sweep;
        // Abort outranks every other transition, including the write-back advance.
        if (abort_req && state != IDLE) begin
            state_nxt = IDLE;
            iter_nxt  = '0;
            p_nxt     = '0;
            q_nxt     = Q_FIRST;
            sweep_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = VEC;
                        iter_nxt  = '0;
                        p_nxt     = '0;
                        q_nxt     = Q_FIRST;
                        sweep_nxt = '0;
                    end
                end
                VEC, ROT: begin
                    if (iter == ITER_LAST) begin
                        state_nxt = (state == VEC) ? ROT : WB;
                        iter_nxt  = '0;
                    end else begin
                        iter_nxt = iter + 1'b1;
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        state_nxt = VEC;
                        iter_nxt  = '0;
                        if (q < Q_LAST) begin
                            q_nxt = q + 1'b1;
                        end else if (p < P_LAST) begin
                            p_nxt = p + 1'b1;
                            q_nxt = p + IDX_W'(2);
                        end else if (sweep == SWEEP_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            sweep_nxt = sweep + 1'b1;
                            p_nxt     = '0;
                            q_nxt     = Q_FIRST;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    iter_nxt  = '0;
                    p_nxt     = '0;
                    q_nxt     = Q_FIRST;
                    sweep_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = 1'b0;
        iter_valid = 1'b0;
        phase      = 1'b0;
        sel        = 1'b0;
        shift_bit  = '0;
        wb_req     = 1'b0;
        p_idx      = '0;
        q_idx      = '0;
        sweep_cnt  = '0;
        case (state)
            VEC, ROT: begin
                iter_valid = 1'b1;
                phase      = (state == ROT);
                sel        = (iter != '0);
                shift_bit  = iter;
            end
            WB:      wb_req = 1'b1;
            DONE:    done   = 1'b1;
            default: ;
        endcase
        if (state != IDLE) begin
            p_idx     = p;
            q_idx     = q;
            sweep_cnt = sweep;
        end
    end

endmodule

// File: tb/tb_svd_jacobi_sched.sv
// Randomized bench for svd_jacobi_sched: a pair-list/cycle-offset model is compared
// against every output on every cycle, plus literal timing and boundary checks.
module tb_svd_jacobi_sched;

    localparam int N_COLS  = 4;
    localparam int IDX_W   = 2;
    localparam int ITER    = 16;
    localparam int SHIFT_W = 4;
    localparam int SWEEPS  = 6;
    localparam int SWEEP_W = 3;
    localparam int NPAIRS  = N_COLS * (N_COLS - 1) / 2;
    localparam int OW      = 6 + SHIFT_W + 2 * IDX_W + SWEEP_W;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic               start  = 1'b0;
    logic               wb_ack = 1'b0;
`ifdef JACOBI_ABORT_EN
    logic               abort  = 1'b0;
`endif
    logic               busy, done, iter_valid, phase, sel, wb_req;
    logic [SHIFT_W-1:0] shift_bit;
    logic [IDX_W-1:0]   p_idx, q_idx;
    logic [SWEEP_W-1:0] sweep_cnt;

    svd_jacobi_sched #(
        .N_COLS (N_COLS),
        .IDX_W  (IDX_W),
        .ITER   (ITER),
        .SHIFT_W(SHIFT_W),
        .SWEEPS (SWEEPS),
        .SWEEP_W(SWEEP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wb_ack    (wb_ack),
`ifdef JACOBI_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .iter_valid(iter_valid),
        .phase     (phase),
        .sel       (sel),
        .shift_bit (shift_bit),
        .p_idx     (p_idx),
        .q_idx     (q_idx),
        .wb_req    (wb_req),
        .sweep_cnt (sweep_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: active decomposition, position in the ordered pair list, sweep, and
    // cycle offset within the pair (0..2*ITER-1 iterating, 2*ITER = write-back).
    int pair_p [NPAIRS];
    int pair_q [NPAIRS];
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_pi     = 0;
    int m_sw     = 0;
    int m_k      = 0;
    logic m_abort;

`ifdef JACOBI_ABORT_EN
    assign m_abort = abort;
`else
    assign m_abort = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_pi     <= 0;
                m_sw     <= 0;
                m_k      <= 0;
            end
        end else if (m_abort) begin
            m_active <= 1'b0;
        end else if (m_k < 2 * ITER) begin
            m_k <= m_k + 1;
        end else if (wb_ack) begin
            m_k <= 0;
            if (m_pi < NPAIRS - 1) begin
                m_pi <= m_pi + 1;
            end else if (m_sw < SWEEPS - 1) begin
                m_pi <= 0;
                m_sw <= m_sw + 1;
            end else begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [OW-1:0] got, exp;
        logic e_busy, e_iv, e_phase, e_sel, e_wb;
        logic [SHIFT_W-1:0] e_shift;
        logic [IDX_W-1:0]   e_p, e_q;
        logic [SWEEP_W-1:0] e_sw;
        if (chk_en) begin
            e_busy  = m_active || m_done;
            e_iv    = m_active && (m_k < 2 * ITER);
            e_phase = e_iv && (m_k >= ITER);
            e_sel   = e_iv && ((m_k % ITER) != 0);
            e_shift = e_iv ? SHIFT_W'(m_k % ITER) : '0;
            e_wb    = m_active && (m_k == 2 * ITER);
            e_p     = e_busy ? IDX_W'(pair_p[m_pi]) : '0;
            e_q     = e_busy ? IDX_W'(pair_q[m_pi]) : '0;
            e_sw    = e_busy ? SWEEP_W'(m_sw) : '0;
            got = {busy, done, iter_valid, phase, sel, wb_req, shift_bit, p_idx, q_idx, sweep_cnt};
            exp = {e_busy, m_done, e_iv, e_phase, e_sel, e_wb, e_shift, e_p, e_q, e_sw};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL outputs t=%0t got %h expected %h (busy,done,iv,phase,sel,wb_req,shift,p,q,sweep)",
                         $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({busy, done, iter_valid, phase, sel, wb_req, shift_bit, p_idx, q_idx, sweep_cnt});
    endfunction

    initial begin
        int n, cyc, cnt, done_cnt;
        bit found, stalled;
        n = 0;
        for (int a = 0; a < N_COLS; a++)
            for (int b = a + 1; b < N_COLS; b++) begin
                pair_p[n] = a;
                pair_q[n] = b;
                n++;
            end

        // Reset state.
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pass with wb_ack tied high and a stray start mid-ROT.
        wb_ack = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_vec_iv", iter_valid, 1);
        chk("first_vec_sel", sel, 0);
        chk("first_vec_shift", shift_bit, 0);
        chk("first_vec_pq", {p_idx, q_idx}, {2'd0, 2'd1});
        cyc = 0;
        found = 1'b0;
        while (cyc < 1300 && !found) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 20);
            if (cyc == 1)  chk("vec_iter1_sel_shift", {sel, shift_bit}, {1'b1, 4'd1});
            if (cyc == 16) chk("rot_first", {phase, sel, shift_bit}, {1'b1, 1'b0, 4'd0});
            if (cyc == 32) chk("wb_first_pair", wb_req, 1);
            if (cyc == 33) chk("second_pair", {iter_valid, p_idx, q_idx}, {1'b1, 2'd0, 2'd2});
            if (done) found = 1'b1;
        end
        start = 1'b0;
        chk("done_latency", found ? cyc : -1, 6 * 6 * 33);
        @(negedge clk);
        chk("idle_after_done", busy, 0);

        // Random acks/starts, a 5-cycle stall on pair (1,2), then reset at sweep 2 pair (0,3).
        wb_ack = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 0;
        found   = 1'b0;
        stalled = 1'b0;
        while (cyc < 3000 && !found) begin
            if (sweep_cnt == 2 && p_idx == 0 && q_idx == 3 && iter_valid) begin
                found = 1'b1;
            end else if (!stalled && wb_req && p_idx == 1 && q_idx == 2 && sweep_cnt == 0) begin
                stalled = 1'b1;
                start   = 1'b0;
                wb_ack  = 1'b0;
                cnt     = 1;
                for (int i = 1; i <= 5; i++) begin
                    @(negedge clk);
                    cyc++;
                    if (wb_req && p_idx == 1 && q_idx == 2) cnt++;
                    if (i == 5) wb_ack = 1'b1;
                end
                @(negedge clk);
                cyc++;
                wb_ack = 1'b0;
                chk("stall_wb_cycles", cnt, 6);
                chk("after_stall", {iter_valid, sel, p_idx, q_idx}, {1'b1, 1'b0, 2'd1, 2'd3});
            end else begin
                wb_ack = ($urandom_range(0, 2) == 0);
                start  = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                cyc++;
            end
        end
        chk("stall_seen", stalled, 1);
        chk("reached_sweep2_pair03", found, 1);
        start  = 1'b0;
        wb_ack = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_outputs", all_outs(), 0);

        // Restart after reset and run to completion with random handshakes.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_pair", {iter_valid, p_idx, q_idx, sweep_cnt}, {1'b1, 2'd0, 2'd1, 3'd0});
        cyc = 0;
        done_cnt = 0;
        found = 1'b0;
        while (cyc < 6000 && !found) begin
            wb_ack = ($urandom_range(0, 3) == 0);
            start  = ($urandom_range(0, 7) == 0);
            if (done) begin
                found = 1'b1;
                done_cnt++;
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_ack = ($urandom_range(0, 1) == 1);
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("done_once", done_cnt, 1);
        chk("idle_ignores_ack", busy, 0);

`ifdef JACOBI_ABORT_EN
        // Abort together with wb_ack in WB; abort in IDLE is harmless.
        wb_ack = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !wb_req) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_wb", wb_req, 1);
        abort  = 1'b1;
        wb_ack = 1'b1;
        @(negedge clk);
        abort  = 1'b0;
        wb_ack = 1'b0;
        chk("abort_outputs", all_outs(), 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_in_idle", {busy, iter_valid}, {1'b1, 1'b1});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/svd_jacobi_sched.md
Name: svd_jacobi_sched

Overview:
- Sequencer for the SVD CORDIC rotation datapath under a one-sided Jacobi schedule.
- Walks all column pairs (p,q) for a fixed number of sweeps.
- For each pair: one CORDIC vectoring pass (angle), then one rotation pass (apply angle). Each pass is ITER micro-iterations, driving the datapath's shift amount and load/feedback mux select.
- Requests a column write-back after each pair and waits for acknowledge before advancing.

Parameters:
N_COLS, 4, number of matrix columns (>=2)
IDX_W, 2, width of column index outputs (>= clog2(N_COLS))
ITER, 16, CORDIC micro-iterations per pass (<= 2**SHIFT_W)
SHIFT_W, 4, width of shift_bit
SWEEPS, 6, Jacobi sweeps per decomposition (>=1)
SWEEP_W, 3, width of sweep counter (>= clog2(SWEEPS))

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin decomposition; sampled only in IDLE
wb_ack  in  1  datapath finished write-back of current pair; honoured only in WB
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of final sweep
iter_valid  out  1  high when shift_bit/sel/phase drive a live micro-iteration
phase  out  1  0 = vectoring, 1 = rotation
sel  out  1  0 = load fresh operands (first iteration of a pass), 1 = feedback
shift_bit  out  SHIFT_W  current micro-iteration index / shift amount
p_idx  out  IDX_W  first column of current pair
q_idx  out  IDX_W  second column of current pair
wb_req  out  1  high throughout WB
sweep_cnt  out  SWEEP_W  current sweep number, 0-based

Behaviour:
- Reset: state IDLE. All outputs 0; p_idx=0, q_idx=1 internally preloaded but driven as 0 while IDLE.
- All outputs are registered (Moore). Internal iteration counter iter runs 0..ITER-1.
- State IDLE:
  - start=1 -> VEC, with iter=0, p=0, q=1, sweep=0.
- State VEC:
  - iter_valid=1, phase=0, shift_bit=iter, sel=(iter!=0).
  - iter increments every cycle.
  - At iter==ITER-1 -> ROT, iter=0.
- State ROT:
  - Same outputs as VEC but phase=1.
  - At iter==ITER-1 -> WB.
- State WB:
  - wb_req=1, iter_valid=0, sel=0, shift_bit=0. Holds indefinitely until wb_ack.
  - On wb_ack, pair advance:
    - if q<N_COLS-1: q<=q+1.
    - else if p<N_COLS-2: p<=p+1, q<=p+2.
    - else end of sweep: if sweep==SWEEPS-1 -> DONE; else sweep<=sweep+1, p<=0, q<=1.
  - Unless DONE, next state is VEC with iter=0.
- State DONE:
  - done=1 for exactly one cycle, busy=1 -> IDLE.
- Timing:
  - Pair latency = 2*ITER cycles + WB dwell (>=1).
  - First VEC cycle follows the start cycle by one clock.
- Boundary conditions:
  - start while busy: ignored.
  - wb_ack outside WB: ignored.
  - wb_ack held high continuously: WB lasts exactly 1 cycle per pair.
  - Reset mid-operation: IDLE on next edge; all counters cleared; no done.
  - N_COLS=2: single pair (0,1) per sweep.
- Widths:
  - iter is SHIFT_W bits and must not wrap inside a pass.
  - p, q, sweep never exceed their maximum values.
  - shift_bit = iter truncated to SHIFT_W.

Optional Feature:
- Macro: JACOBI_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any busy state forces IDLE on the next edge and clears counters.
  - done is not pulsed.
  - abort has priority over wb_ack and over iter/state advance in the same cycle.
  - abort in IDLE has no effect.
- Undefined: port absent; a decomposition can be terminated only by reset.

Test Plan:
- Basic pass, defaults, wb_ack tied 1:
  - start -> pairs in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3), repeated for sweep_cnt 0..5.
  - Each pair occupies 33 cycles.
  - done pulses once, 6*6*33=1188 cycles after the first VEC cycle.
- Micro-iteration outputs:
  - In VEC, shift_bit runs 0..15 with sel=0,1,1,...,1 and phase=0.
  - Then ROT repeats the same sequence with phase=1.
  - iter_valid=1 for 32 consecutive cycles per pair.
- Write-back stall:
  - Delay wb_ack by 5 cycles on pair (1,2): wb_req stays high 6 cycles; p_idx/q_idx hold 1/2.
  - VEC restarts with (1,3) the cycle after wb_ack.
- Ignored inputs:
  - Pulse start mid-ROT and wb_ack mid-VEC: no change to the sequence or counters.
- Reset mid-run:
  - Drop rst_n during sweep 2, pair (0,3): next cycle busy=0, all outputs 0.
  - A new start begins at (0,1), sweep 0.
- Abort (JACOBI_ABORT_EN):
  - Assert abort together with wb_ack in WB: next cycle IDLE, done never asserted.
  - abort in IDLE: no effect.
